// File: rtl/zx_clk_pkg.sv
// Shared constants and helpers for the Spectrum clock-enable / turbo block.
package zx_clk_pkg;

  localparam int unsigned LEVELS_DEF  = 5;
  localparam int unsigned CNT_W_DEF   = 6;
  localparam int unsigned CE28_LOG2   = 2;
  localparam int unsigned CE7_LOG2    = 4;
  localparam int unsigned GAP_W       = 3;

  typedef enum logic {
    CPU_RUN  = 1'b0,
    CPU_HALT = 1'b1
  } cpu_state_e;

  // Low 'levels' bits set, shifted down by the level: period halves per level.
  function automatic logic [31:0] turbo_mask(input int unsigned levels,
                                             input int unsigned level);
    logic [31:0] full;
    full = (32'd1 << levels) - 32'd1;
    return full >> level;
  endfunction

  function automatic int unsigned clamp_level(input int unsigned levels,
                                              input int unsigned req);
    return (req >= levels) ? levels - 1 : req;
  endfunction

endpackage

// File: rtl/zx_ce_turbo_if.sv
// Strobe / status bundle produced by zx_ce_turbo for the rest of the host board.
interface zx_ce_turbo_if #(
  parameter int unsigned LVL_W = 3
);
  logic             ce_28m;
  logic             ce_7mp;
  logic             ce_7mn;
  logic             ce_psg;
  logic             cpu_p;
  logic             cpu_n;
  logic             ce_cpu_p;
  logic             ce_cpu_n;
  logic             ce_cpu;
  logic             cpu_en;
  logic             paused;
  logic [LVL_W-1:0] level_cur;

  modport master (
    output ce_28m, ce_7mp, ce_7mn, ce_psg, cpu_p, cpu_n,
           ce_cpu_p, ce_cpu_n, ce_cpu, cpu_en, paused, level_cur
  );

  modport slave (
    input ce_28m, ce_7mp, ce_7mn, ce_psg, cpu_p, cpu_n,
          ce_cpu_p, ce_cpu_n, ce_cpu, cpu_en, paused, level_cur
  );
endinterface

// File: rtl/zx_ce_divider.sv
// Free-running master counter plus the fixed-rate registered strobes.
module zx_ce_divider
  import zx_clk_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned PSG_LOG2 = 6
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             paused_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ce_28m_o,
  output logic             ce_7mp_o,
  output logic             ce_7mn_o,
  output logic             ce_psg_o
);

  localparam logic [CE7_LOG2-1:0] CE7_HALF = CE7_LOG2'(1 << (CE7_LOG2 - 1));

  logic [CNT_W-1:0] cnt_q;
  logic             ce_28m_q;
  logic             ce_7mp_q;
  logic             ce_7mn_q;
  logic             ce_psg_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q    <= '0;
      ce_28m_q <= 1'b0;
      ce_7mp_q <= 1'b0;
      ce_7mn_q <= 1'b0;
      ce_psg_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_q + CNT_W'(1);
      ce_28m_q <= (cnt_q[CE28_LOG2-1:0] == '0);
      ce_7mp_q <= (cnt_q[CE7_LOG2-1:0] == '0);
      ce_7mn_q <= (cnt_q[CE7_LOG2-1:0] == CE7_HALF);
      ce_psg_q <= (cnt_q[PSG_LOG2-1:0] == '0) && !paused_i;
    end
  end

  assign cnt_o    = cnt_q;
  assign ce_28m_o = ce_28m_q;
  assign ce_7mp_o = ce_7mp_q;
  assign ce_7mn_o = ce_7mn_q;
  assign ce_psg_o = ce_psg_q;

endmodule

// File: rtl/zx_ce_turbo.sv
// Turbo-level CPU strobe generation with switch gap, pause and SDRAM/tape stalls.
module zx_ce_turbo
  import zx_clk_pkg::*;
#(
  parameter int unsigned LEVELS       = LEVELS_DEF,
  parameter int unsigned LVL_W        = 3,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned PSG_LOG2     = 6,
  parameter int unsigned SWITCH_GAP   = 3,
  parameter int unsigned RAM_WAIT_LVL = 3
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [LVL_W-1:0] level_req,
  input  logic             pause_tgl,
  input  logic             ram_ready,
  input  logic             tape_active,
  input  logic             sync_p,
  input  logic             sync_n,
  zx_ce_turbo_if.master    bus
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] mask;
  logic [CNT_W-1:0] half;
  logic [LVL_W-1:0] lvl_req_c;
  logic [31:0]      lvl_cur32;
  logic             cpu_p_c;
  logic             cpu_n_c;
  logic             cpu_en_c;

  cpu_state_e       state_q;
  logic [GAP_W-1:0] gap_q;
  logic [LVL_W-1:0] level_cur_q;
  logic             paused_q;
  logic             pause_d_q;
  logic             tp_q;
  logic             tn_q;

  zx_ce_divider #(
    .CNT_W    (CNT_W),
    .PSG_LOG2 (PSG_LOG2)
  ) u_div (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .paused_i (paused_q),
    .cnt_o    (cnt),
    .ce_28m_o (bus.ce_28m),
    .ce_7mp_o (bus.ce_7mp),
    .ce_7mn_o (bus.ce_7mn),
    .ce_psg_o (bus.ce_psg)
  );

  assign mask      = CNT_W'(turbo_mask(LEVELS, 32'(level_cur_q)));
  assign half      = mask ^ (mask >> 1);
  assign lvl_req_c = LVL_W'(clamp_level(LEVELS, 32'(level_req)));
  assign lvl_cur32 = 32'(level_cur_q);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tp_q <= 1'b0;
      tn_q <= 1'b0;
    end else begin
      tp_q <= ((cnt & mask) == '0);
      tn_q <= ((cnt & mask) == half);
    end
  end

  assign cpu_p_c  = (level_cur_q == '0) ? sync_p : tp_q;
  assign cpu_n_c  = (level_cur_q == '0) ? sync_n : tn_q;
  assign cpu_en_c = (state_q == CPU_RUN);

  // Gap advances on every cpu_n independently of which control branch fires;
  // a switch overrides it back to 1.  pause_d_q tracks the input even in reset
  // so a level held across reset is not seen as a fresh edge.
  always_ff @(posedge clk_sys) begin
    pause_d_q <= pause_tgl;
    if (reset) begin
      state_q     <= CPU_RUN;
      gap_q       <= '0;
      level_cur_q <= '0;
      paused_q    <= 1'b0;
    end else begin
      if (pause_tgl && !pause_d_q) paused_q <= !paused_q;
      if (cpu_n_c) begin
        if (gap_q != '0)
          gap_q <= (gap_q == GAP_W'(SWITCH_GAP)) ? '0 : gap_q + GAP_W'(1);
        if (level_cur_q != lvl_req_c) begin
          state_q     <= CPU_HALT;
          gap_q       <= GAP_W'(1);
          level_cur_q <= lvl_req_c;
        end else if (state_q == CPU_HALT && gap_q == '0 && ram_ready) begin
          state_q <= paused_q ? CPU_HALT : CPU_RUN;
        end else if (lvl_cur32 >= RAM_WAIT_LVL && !ram_ready) begin
          state_q <= CPU_HALT;
        end else if (lvl_cur32 >= RAM_WAIT_LVL - 1 && !ram_ready && tape_active) begin
          state_q <= CPU_HALT;
        end else if (state_q == CPU_RUN && paused_q) begin
          state_q <= CPU_HALT;
        end
      end
    end
  end

  assign bus.cpu_p     = cpu_p_c;
  assign bus.cpu_n     = cpu_n_c;
  assign bus.ce_cpu_p  = cpu_p_c & cpu_en_c;
  assign bus.ce_cpu_n  = cpu_n_c & cpu_en_c;
  assign bus.ce_cpu    = tp_q & cpu_en_c;
  assign bus.cpu_en    = cpu_en_c;
  assign bus.paused    = paused_q;
  assign bus.level_cur = level_cur_q;

endmodule

// File: tb/tb_zx_ce_turbo.sv
// Directed, table-driven bench for zx_ce_turbo with default parameters.
module tb_zx_ce_turbo;

  localparam int unsigned LVL_W = 3;

  logic             clk_sys     = 1'b0;
  logic             reset       = 1'b1;
  logic [LVL_W-1:0] level_req   = '0;
  logic             pause_tgl   = 1'b0;
  logic             ram_ready   = 1'b1;
  logic             tape_active = 1'b0;
  logic             sync_p      = 1'b0;
  logic             sync_n      = 1'b0;
  bit               sync_en     = 1'b0;
  int unsigned      cyc         = 0;
  int               n_chk       = 0;
  int               n_fail      = 0;

  zx_ce_turbo_if #(.LVL_W(LVL_W)) bus ();

  zx_ce_turbo #(
    .LEVELS       (5),
    .LVL_W        (LVL_W),
    .CNT_W        (6),
    .PSG_LOG2     (6),
    .SWITCH_GAP   (3),
    .RAM_WAIT_LVL (3)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .level_req   (level_req),
    .pause_tgl   (pause_tgl),
    .ram_ready   (ram_ready),
    .tape_active (tape_active),
    .sync_p      (sync_p),
    .sync_n      (sync_n),
    .bus         (bus)
  );

  initial forever #5 clk_sys = ~clk_sys;

  // Video-style strobes: sync_p every 32 clocks, sync_n half a period later.
  initial forever begin
    @(negedge clk_sys);
    cyc++;
    sync_p = sync_en && (cyc % 32 == 0);
    sync_n = sync_en && (cyc % 32 == 16);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk_sys);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic sig(input int idx);
    case (idx)
      0:       return bus.ce_28m;
      1:       return bus.ce_7mp;
      2:       return bus.ce_7mn;
      3:       return bus.ce_psg;
      4:       return bus.cpu_p;
      5:       return bus.cpu_n;
      default: return bus.ce_cpu_p;
    endcase
  endfunction

  task automatic wait_for(input int idx, input string name, output int n);
    n = 0;
    while (!sig(idx)) begin
      if (n >= 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s: strobe %0d timed out after %0d cycles, required within 200", name, idx, n);
        break;
      end
      step();
      n++;
    end
  endtask

  task automatic cpu_n_update(input string name);
    int n;
    wait_for(5, name, n);
    step();
  endtask

  task automatic period_of(input int idx, input string name, output int per);
    int n;
    wait_for(idx, name, n);
    step();
    wait_for(idx, name, n);
    per = n + 1;
  endtask

  task automatic offset_of(input int a, input int b, input string name, output int off);
    int n;
    wait_for(a, name, n);
    step();
    wait_for(b, name, n);
    off = n + 1;
  endtask

  task automatic count_of(input int idx, input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      step();
      if (sig(idx)) cnt++;
    end
  endtask

  task automatic wait_enabled(input string name);
    int k;
    k = 0;
    while (!bus.cpu_en && k < 8) begin
      cpu_n_update(name);
      k++;
    end
    chk(name, int'(bus.cpu_en), 1);
  endtask

  task automatic pulse_pause();
    pause_tgl = 1'b1;
    step();
    pause_tgl = 1'b0;
  endtask

  typedef struct {
    logic [LVL_W-1:0] req;
    int               exp_lvl;
    int               exp_per;
    int               exp_off;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int v, bad, n, per, off;

    tbl[0] = '{req: 3'd1, exp_lvl: 1, exp_per: 16, exp_off: 8};
    tbl[1] = '{req: 3'd3, exp_lvl: 3, exp_per: 4,  exp_off: 2};
    tbl[2] = '{req: 3'd7, exp_lvl: 4, exp_per: 2,  exp_off: 1};
    tbl[3] = '{req: 3'd5, exp_lvl: 4, exp_per: 2,  exp_off: 1};
    tbl[4] = '{req: 3'd2, exp_lvl: 2, exp_per: 8,  exp_off: 4};
    tbl[5] = '{req: 3'd0, exp_lvl: 0, exp_per: 32, exp_off: 16};

    // Reset state
    step(3);
    chk("rst_ce_28m", int'(bus.ce_28m), 0);
    chk("rst_ce_psg", int'(bus.ce_psg), 0);
    chk("rst_cpu_en", int'(bus.cpu_en), 1);
    chk("rst_paused", int'(bus.paused), 0);
    chk("rst_level", int'(bus.level_cur), 0);
    reset = 1'b0;
    step();
    chk("first_ce_28m", int'(bus.ce_28m), 1);
    chk("first_ce_7mp", int'(bus.ce_7mp), 1);
    chk("first_ce_7mn", int'(bus.ce_7mn), 0);
    chk("first_ce_psg", int'(bus.ce_psg), 1);
    sync_en = 1'b1;

    // Fixed strobes at level 0
    period_of(0, "p28", per);   chk("ce_28m_period", per, 4);
    period_of(1, "p7p", per);   chk("ce_7mp_period", per, 16);
    period_of(2, "p7n", per);   chk("ce_7mn_period", per, 16);
    offset_of(1, 2, "o7", off); chk("ce_7mp_to_7mn", off, 8);
    period_of(3, "ppsg", per);  chk("ce_psg_period", per, 64);

    bad = 0;
    n = 0;
    repeat (64) begin
      step();
      if (bus.cpu_p !== sync_p || bus.cpu_n !== sync_n) bad++;
      if (!bus.cpu_en) bad++;
      if (bus.ce_cpu) n++;
    end
    chk("lvl0_sync_mirror_en", bad, 0);
    chk("lvl0_ce_cpu_count", n, 2);

    // Switch 0 -> 2: gap of SWITCH_GAP cpu_n strobes
    level_req = 3'd2;
    cpu_n_update("sw2");
    chk("sw2_level", int'(bus.level_cur), 2);
    chk("sw2_cpu_en_drop", int'(bus.cpu_en), 0);
    for (int i = 1; i <= 3; i++) begin
      cpu_n_update("sw2_gap");
      chk($sformatf("sw2_gap_hold%0d", i), int'(bus.cpu_en), 0);
    end
    cpu_n_update("sw2_re");
    chk("sw2_reenable_4th", int'(bus.cpu_en), 1);
    period_of(4, "sw2_per", per);
    chk("sw2_tp_period", per, 8);

    // Level 4 with SDRAM stall
    level_req = 3'd4;
    cpu_n_update("sw4");
    chk("sw4_level", int'(bus.level_cur), 4);
    wait_enabled("sw4_enabled");
    ram_ready = 1'b0;
    cpu_n_update("ram_stall");
    chk("ram_stall_en", int'(bus.cpu_en), 0);
    count_of(6, 18, n);
    chk("ram_stall_no_ce_cpu_p", n, 0);
    ram_ready = 1'b1;
    cpu_n_update("ram_back");
    chk("ram_back_en", int'(bus.cpu_en), 1);

    // Tape stall thresholds
    level_req = 3'd2;
    cpu_n_update("sw2b");
    wait_enabled("sw2b_enabled");
    ram_ready = 1'b0;
    cpu_n_update("l2_noram");
    cpu_n_update("l2_noram");
    chk("l2_noram_notape_en", int'(bus.cpu_en), 1);
    tape_active = 1'b1;
    cpu_n_update("l2_tape");
    chk("l2_tape_stall_en", int'(bus.cpu_en), 0);
    ram_ready = 1'b1;
    tape_active = 1'b0;
    cpu_n_update("l2_tape_back");
    chk("l2_tape_back_en", int'(bus.cpu_en), 1);
    level_req = 3'd1;
    cpu_n_update("sw1");
    wait_enabled("sw1_enabled");
    ram_ready = 1'b0;
    tape_active = 1'b1;
    cpu_n_update("l1_tape");
    cpu_n_update("l1_tape");
    chk("l1_tape_no_stall_en", int'(bus.cpu_en), 1);
    ram_ready = 1'b1;
    tape_active = 1'b0;

    // Pause
    pulse_pause();
    chk("pause_on", int'(bus.paused), 1);
    cpu_n_update("pause_drop");
    chk("pause_cpu_en", int'(bus.cpu_en), 0);
    count_of(3, 130, n);
    chk("pause_no_psg", n, 0);
    pulse_pause();
    chk("pause_off", int'(bus.paused), 0);
    cpu_n_update("pause_back");
    chk("unpause_cpu_en", int'(bus.cpu_en), 1);
    count_of(3, 128, n);
    chk("unpause_psg_count", n, 2);

    // Reset while paused, with a simultaneous toggle edge
    pulse_pause();
    chk("pause_again", int'(bus.paused), 1);
    level_req = 3'd0;
    reset = 1'b1;
    pause_tgl = 1'b1;
    step();
    pause_tgl = 1'b0;
    step();
    chk("rst_pause_cleared", int'(bus.paused), 0);
    chk("rst_pause_level", int'(bus.level_cur), 0);
    chk("rst_pause_en", int'(bus.cpu_en), 1);
    reset = 1'b0;
    step(3);
    chk("post_rst_paused", int'(bus.paused), 0);

    // Level change in the middle of a gap restarts it
    level_req = 3'd2;
    cpu_n_update("mg_sw2");
    chk("mg_level2", int'(bus.level_cur), 2);
    cpu_n_update("mg_gap");
    level_req = 3'd3;
    cpu_n_update("mg_sw3");
    chk("mg_level3", int'(bus.level_cur), 3);
    chk("mg_en_after_sw3", int'(bus.cpu_en), 0);
    for (int i = 1; i <= 3; i++) begin
      cpu_n_update("mg_gap");
      chk($sformatf("mg_gap_hold%0d", i), int'(bus.cpu_en), 0);
    end
    cpu_n_update("mg_re");
    chk("mg_reenable", int'(bus.cpu_en), 1);

    // Table: level request, clamp, strobe period and p->n spacing
    for (v = 0; v < 6; v++) begin
      level_req = tbl[v].req;
      cpu_n_update($sformatf("tbl%0d_sw", v));
      chk($sformatf("tbl%0d_level", v), int'(bus.level_cur), tbl[v].exp_lvl);
      wait_enabled($sformatf("tbl%0d_enabled", v));
      wait_for(4, $sformatf("tbl%0d_align", v), n);
      chk($sformatf("tbl%0d_ce_cpu_p", v), int'(bus.ce_cpu_p), 1);
      offset_of(4, 5, $sformatf("tbl%0d_off", v), off);
      step();
      wait_for(4, $sformatf("tbl%0d_per", v), n);
      chk($sformatf("tbl%0d_offset", v), off, tbl[v].exp_off);
      chk($sformatf("tbl%0d_period", v), off + 1 + n, tbl[v].exp_per);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
